uart_rx_byte: RTL and testbench

//   Serial UART receiver: 8 data bits, LSB first, optional parity, 1 stop bit.

---
 rtl/uart_rx_byte_if.sv | 22 ++
 rtl/uart_rx_byte.sv | 158 +++++++++++++++
 tb/tb_uart_rx_byte.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_byte_if.sv
// Received-byte bundle from the UART receiver to the FIFO stage.
// master drives the byte and status pulses, slave observes them.
interface uart_rx_byte_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_frame_err;
    logic       rx_parity_err;

    modport master (
        output rx_data,
        output rx_done,
        output rx_frame_err,
        output rx_parity_err
    );

    modport slave (
        input rx_data,
        input rx_done,
        input rx_frame_err,
        input rx_parity_err
    );
endinterface

// File: rtl/uart_rx_byte.sv
// UART receiver: 8N1 / 8O1 / 8E1, mid-bit sampling, glitch rejection,
// frame and parity error pulses, one byte per rx_done pulse.
module uart_rx_byte #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int PARITY    = 0
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            uart_rxd,
    uart_rx_byte_if.master  rx
);

    localparam int BIT_CNT = CLK_FREQ / BAUD_RATE;
    localparam int CW      = $clog2(BIT_CNT);

    localparam logic [CW-1:0] HALF = CW'(BIT_CNT / 2);
    localparam logic [CW-1:0] LAST = CW'(BIT_CNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BRK
    } state_t;

    state_t        state;
    logic          rxd_m;
    logic          rxd_s;
    logic          rxd_d;
    logic [1:0]    settle;
    logic          armed;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          par_bad;
    logic [7:0]    data_q;
    logic          done_q;
    logic          ferr_q;
    logic          perr_q;
    logic          fall;
    logic          tick;

    // A line that is low when reset releases must first go high before a
    // falling edge counts, so edges are ignored until the synchroniser has
    // flushed its reset value and seen a real high level.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rxd_m  <= 1'b1;
            rxd_s  <= 1'b1;
            rxd_d  <= 1'b1;
            settle <= 2'd0;
            armed  <= 1'b0;
        end else begin
            rxd_m <= uart_rxd;
            rxd_s <= rxd_m;
            rxd_d <= rxd_s;
            if (settle != 2'd3)
                settle <= settle + 2'd1;
            if (settle == 2'd3 && rxd_s)
                armed <= 1'b1;
        end
    end

    assign fall    = armed & rxd_d & ~rxd_s;
    assign tick    = (cnt == HALF);
    assign cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;

    // Frame FSM with bit-period counter, shift register and registered pulses.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= 3'd0;
            shreg   <= 8'h00;
            par_bad <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            perr_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (fall) begin
                        state   <= START;
                        par_bad <= 1'b0;
                    end
                end
                START: begin
                    cnt <= cnt_nxt;
                    if (tick) begin
                        if (rxd_s) begin
                            state <= IDLE;
                        end else begin
                            state <= DATA;
                            idx   <= 3'd0;
                        end
                    end
                end
                DATA: begin
                    cnt <= cnt_nxt;
                    if (tick) begin
                        shreg <= {rxd_s, shreg[7:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7)
                            state <= (PARITY != 0) ? PAR : STOP;
                    end
                end
                PAR: begin
                    cnt <= cnt_nxt;
                    if (tick) begin
                        par_bad <= (^shreg) ^ rxd_s ^ (PARITY == 1);
                        state   <= STOP;
                    end
                end
                STOP: begin
                    cnt <= cnt_nxt;
                    if (tick) begin
                        if (rxd_s) begin
                            state <= IDLE;
                            if (par_bad) begin
                                perr_q <= 1'b1;
                            end else begin
                                done_q <= 1'b1;
                                data_q <= shreg;
                            end
                        end else begin
                            state  <= BRK;
                            ferr_q <= 1'b1;
                        end
                    end
                end
                BRK: begin
                    cnt <= '0;
                    if (rxd_s)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign rx.rx_data       = data_q;
    assign rx.rx_done       = done_q;
    assign rx.rx_frame_err  = ferr_q;
    assign rx.rx_parity_err = perr_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: one nominal-rate receiver and three fast ones
// (none/even/odd parity) checked against a frame-level event model.
module tb_uart_rx_byte;

    localparam int PAR [4] = '{0, 0, 2, 1};
    localparam real NOM = 434.0;
    localparam real FST = 32.0;

    logic clk;
    logic rst_n;
    logic rxd [4];
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   onehot_viol;
    int   done_cyc [4];
    logic [7:0] last_good [4];
    int   exp_q [4][$];

    uart_rx_byte_if if0 ();
    uart_rx_byte_if if1 ();
    uart_rx_byte_if if2 ();
    uart_rx_byte_if if3 ();

    uart_rx_byte u_nom (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .uart_rxd (rxd[0]),
        .rx       (if0)
    );

    uart_rx_byte #(
        .CLK_FREQ  (50_000_000),
        .BAUD_RATE (1_562_500),
        .PARITY    (0)
    ) u_f0 (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .uart_rxd (rxd[1]),
        .rx       (if1)
    );

    uart_rx_byte #(
        .CLK_FREQ  (50_000_000),
        .BAUD_RATE (1_562_500),
        .PARITY    (2)
    ) u_fe (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .uart_rxd (rxd[2]),
        .rx       (if2)
    );

    uart_rx_byte #(
        .CLK_FREQ  (50_000_000),
        .BAUD_RATE (1_562_500),
        .PARITY    (1)
    ) u_fo (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .uart_rxd (rxd[3]),
        .rx       (if3)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pops the next expected event (kind*256 + rx_data) on any pulse.
    task automatic mon(input int s, input logic d, input logic fe,
                       input logic pe, input logic [7:0] q);
        int n;
        int k;
        int e;
        if (!rst_n) return;
        n = int'(d) + int'(fe) + int'(pe);
        if (n > 1) onehot_viol++;
        if (n == 0) return;
        k = d ? 0 : (fe ? 1 : 2);
        done_cyc[s] = cyc;
        if (exp_q[s].size() == 0) begin
            check($sformatf("d%0d_unexpected", s), k + 1, 0);
        end else begin
            e = exp_q[s].pop_front();
            check($sformatf("d%0d_kind", s), k, e / 256);
            check($sformatf("d%0d_data", s), {24'd0, q}, e % 256);
        end
    endtask

    always @(negedge clk)
        mon(0, if0.rx_done, if0.rx_frame_err, if0.rx_parity_err, if0.rx_data);
    always @(negedge clk)
        mon(1, if1.rx_done, if1.rx_frame_err, if1.rx_parity_err, if1.rx_data);
    always @(negedge clk)
        mon(2, if2.rx_done, if2.rx_frame_err, if2.rx_parity_err, if2.rx_data);
    always @(negedge clk)
        mon(3, if3.rx_done, if3.rx_frame_err, if3.rx_parity_err, if3.rx_data);

    // Called at a negedge; returns at the negedge ending the stop bit.
    // Bit boundaries are rounded from a real period to model baud mismatch.
    task automatic send_frame(input int s, input logic [7:0] d,
                              input bit bad_par, input bit stop,
                              input real per, input int hold);
        logic [10:0] bits;
        logic        p;
        int          nb;
        int          t;
        int          tgt;
        int          kind;
        p = (PAR[s] == 1) ? ~(^d) : ^d;
        if (bad_par) p = ~p;
        if (PAR[s] != 0) begin
            nb   = 11;
            bits = {stop, p, d, 1'b0};
        end else begin
            nb   = 10;
            bits = {1'b0, stop, d, 1'b0};
        end
        if (!stop)
            kind = 1;
        else if (PAR[s] != 0 && bad_par)
            kind = 2;
        else
            kind = 0;
        if (kind == 0) last_good[s] = d;
        exp_q[s].push_back(kind * 256 + int'(last_good[s]));
        t = 0;
        for (int k = 0; k < nb; k++) begin
            rxd[s] = bits[k];
            tgt = $rtoi((k + 1) * per + 0.5);
            while (t < tgt) begin
                @(negedge clk);
                t++;
            end
        end
        if (!stop) begin
            repeat (hold) @(negedge clk);
            rxd[s] = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            exp_q[s].delete();
            last_good[s] = 8'h00;
        end
    endtask

    task automatic random_run(input int s, input int frames);
        bit   st;
        bit   bp;
        real  per;
        int   hold;
        for (int i = 0; i < frames; i++) begin
            st   = ($urandom_range(0, 7) != 0);
            bp   = ($urandom_range(0, 3) == 0);
            per  = FST * real'($urandom_range(975, 1025)) / 1000.0;
            hold = $urandom_range(0, 96);
            send_frame(s, 8'($urandom), bp, st, per, hold);
            if (!st)
                idle(8 + $urandom_range(0, 20));
            else
                idle($urandom_range(0, 40));
        end
    endtask

    initial begin
        #(20 * 200_000);
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int lat;
        cyc         = 0;
        n_checks    = 0;
        n_errors    = 0;
        onehot_viol = 0;
        rst_n       = 1'b0;
        for (int s = 0; s < 4; s++) begin
            rxd[s]      = 1'b1;
            done_cyc[s] = -1;
        end
        model_reset();
        idle(5);
        check("rst_data0", {24'd0, if0.rx_data}, 0);
        check("rst_done0", {31'd0, if0.rx_done}, 0);
        check("rst_ferr0", {31'd0, if0.rx_frame_err}, 0);
        check("rst_perr2", {31'd0, if2.rx_parity_err}, 0);
        rst_n = 1'b1;
        idle(10);

        lat = cyc;
        send_frame(0, 8'hA5, 1'b0, 1'b1, NOM, 0);
        idle(50);
        lat = done_cyc[0] - lat;
        check("latency_a5", (lat >= 4125 && lat <= 4127) ? 4126 : lat, 4126);

        rxd[0] = 1'b0;
        idle(100);
        rxd[0] = 1'b1;
        idle(700);

        send_frame(0, 8'hFF, 1'b0, 1'b1, NOM / 1.03, 0);
        idle(20);
        send_frame(0, 8'h00, 1'b0, 1'b1, NOM / 1.03, 0);
        idle(20);
        send_frame(0, 8'hFF, 1'b0, 1'b1, NOM / 0.97, 0);
        idle(20);
        send_frame(0, 8'h00, 1'b0, 1'b1, NOM / 0.97, 0);
        idle(20);

        send_frame(1, 8'h77, 1'b0, 1'b1, FST, 0);
        idle(10);
        send_frame(1, 8'h3C, 1'b0, 1'b0, FST, 2000);
        idle(20);
        check("ferr_keeps_data", {24'd0, if1.rx_data}, 8'h77);
        for (int i = 0; i < 16; i++)
            send_frame(1, 8'(i), 1'b0, 1'b1, FST, 0);
        idle(20);

        send_frame(2, 8'h01, 1'b1, 1'b1, FST, 0);
        idle(5);
        send_frame(2, 8'h01, 1'b0, 1'b1, FST, 0);
        idle(20);
        send_frame(3, 8'h01, 1'b0, 1'b1, FST, 0);
        idle(5);
        send_frame(3, 8'h80, 1'b1, 1'b1, FST, 0);
        idle(20);

        rxd[1] = 1'b0;
        idle(32);
        for (int k = 0; k < 4; k++) begin
            rxd[1] = k[0] ? 1'b0 : 1'b1;
            idle(32);
        end
        rxd[1] = 1'b1;
        idle(16);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("abort_data1", {24'd0, if1.rx_data}, 0);
        check("abort_done1", {31'd0, if1.rx_done}, 0);
        check("abort_data2", {24'd0, if2.rx_data}, 0);
        idle(3);
        rst_n = 1'b1;
        idle(20);
        send_frame(1, 8'h5A, 1'b0, 1'b1, FST, 0);
        idle(20);

        rst_n = 1'b0;
        model_reset();
        rxd[1] = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(200);
        rxd[1] = 1'b1;
        idle(40);
        send_frame(1, 8'hC3, 1'b0, 1'b1, FST, 0);
        idle(20);

        fork
            random_run(1, 25);
            random_run(2, 25);
            random_run(3, 25);
        join
        idle(100);

        for (int s = 0; s < 4; s++)
            check($sformatf("d%0d_missing", s), exp_q[s].size(), 0);
        check("onehot", onehot_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
